// File: rtl/rgb2ycbcr_stream.sv
// -----------------------------------------------------------------------------
// rgb2ycbcr_stream
//
// Streaming RGB -> YCbCr (BT.601 studio range) converter with an AXI4-Stream
// video style handshake on both sides. The datapath has three stages:
//   S1 (p0): nine coefficient x pixel products
//   S2 (p1): three signed sums including the +128 rounding constant
//   S3 (p2): arithmetic shift by 8, offset, clamp and pack
// All stages advance together on en = !m_axis_video_tvalid || m_axis_video_tready.
//
// Optional build macro: RGB2YCBCR_SKID_EN
//   defined   - a 2-entry skid buffer feeds S1; s_axis_video_tready comes
//               straight from a register (latency 4 clk).
//   undefined - s_axis_video_tready follows en combinationally (latency 3 clk).
//
// Ports
//   clk                  in   rising-edge clock
//   rst                  in   asynchronous active-high reset
//   s_axis_video_tdata   in   24  {R[23:16], B[15:8], G[7:0]}
//   s_axis_video_tvalid  in   1
//   s_axis_video_tready  out  1
//   s_axis_video_tlast   in   1   end of line
//   s_axis_video_tuser   in   1   start of frame
//   m_axis_video_tdata   out  24  {Cr[23:16], Cb[15:8], Y[7:0]}
//   m_axis_video_tvalid  out  1
//   m_axis_video_tready  in   1
//   m_axis_video_tlast   out  1
//   m_axis_video_tuser   out  1
// -----------------------------------------------------------------------------
module rgb2ycbcr_stream (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] s_axis_video_tdata,
   input  logic        s_axis_video_tvalid,
   output logic        s_axis_video_tready,
   input  logic        s_axis_video_tlast,
   input  logic        s_axis_video_tuser,
   output logic [23:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   input  logic        m_axis_video_tready,
   output logic        m_axis_video_tlast,
   output logic        m_axis_video_tuser
);

   localparam int DATA_W = 8;
   localparam int COEF_W = 9;
   // Intermediates are 18 bits so that full-scale inputs (e.g. 129*255 or the
   // white-pixel Y sum of 56228) cannot wrap.
   localparam int PROD_W = 18;

   localparam logic signed [COEF_W-1:0] C_YR  =  9'sd66;
   localparam logic signed [COEF_W-1:0] C_YG  =  9'sd129;
   localparam logic signed [COEF_W-1:0] C_YB  =  9'sd25;
   localparam logic signed [COEF_W-1:0] C_CBR = -9'sd38;
   localparam logic signed [COEF_W-1:0] C_CBG = -9'sd74;
   localparam logic signed [COEF_W-1:0] C_CBB =  9'sd112;
   localparam logic signed [COEF_W-1:0] C_CRR =  9'sd112;
   localparam logic signed [COEF_W-1:0] C_CRG = -9'sd94;
   localparam logic signed [COEF_W-1:0] C_CRB = -9'sd18;

   localparam logic signed [PROD_W-1:0] RND    = 18'sd128;
   localparam logic signed [PROD_W-1:0] OFF_Y  = 18'sd16;
   localparam logic signed [PROD_W-1:0] OFF_C  = 18'sd128;
   localparam logic signed [PROD_W-1:0] MIN_YC = 18'sd16;
   localparam logic signed [PROD_W-1:0] MAX_Y  = 18'sd235;
   localparam logic signed [PROD_W-1:0] MAX_C  = 18'sd240;

   // unsigned pixel times signed coefficient, sign-extended to PROD_W
   function automatic logic signed [PROD_W-1:0] coef_mul(
      input logic [DATA_W-1:0]        pix,
      input logic signed [COEF_W-1:0] coef
   );
      logic signed [PROD_W-1:0] pe;
      logic signed [PROD_W-1:0] ce;
      pe = {{(PROD_W-DATA_W){1'b0}}, pix};
      ce = {{(PROD_W-COEF_W){coef[COEF_W-1]}}, coef};
      return pe * ce;
   endfunction

   // drop the 8 fraction bits (rounding constant already added), offset, clamp
   function automatic logic [DATA_W-1:0] shift_sat(
      input logic signed [PROD_W-1:0] sum,
      input logic signed [PROD_W-1:0] off,
      input logic signed [PROD_W-1:0] lo,
      input logic signed [PROD_W-1:0] hi
   );
      logic signed [PROD_W-1:0] v;
      logic [DATA_W-1:0]        r;
      v = (sum >>> 8) + off;
      if (v < lo)
         r = lo[DATA_W-1:0];
      else if (v > hi)
         r = hi[DATA_W-1:0];
      else
         r = v[DATA_W-1:0];
      return r;
   endfunction

   logic        en;
   logic        feed_vld;
   logic [25:0] feed_beat;   // {tuser, tlast, tdata}

   logic                     vld_p0_q, last_p0_q, user_p0_q;
   logic signed [PROD_W-1:0] prod_p0_q [9];
   logic                     vld_p1_q, last_p1_q, user_p1_q;
   logic signed [PROD_W-1:0] y_p1_q, cb_p1_q, cr_p1_q;
   logic                     vld_p2_q, last_p2_q, user_p2_q;
   logic [23:0]              data_p2_q;

   logic [DATA_W-1:0] pix_r, pix_g, pix_b;

   assign en = !vld_p2_q || m_axis_video_tready;

`ifdef RGB2YCBCR_SKID_EN
   // Two-entry buffer: ent0 is always the head. Because tready is registered,
   // one more beat can arrive in the cycle en drops; the second entry holds it.
   logic [1:0]  cnt_q, cnt_d;
   logic [25:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic        rdy_q;
   logic        push, pop;
   logic [25:0] in_beat;

   assign in_beat = {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
   assign push    = s_axis_video_tvalid && rdy_q;
   assign pop     = en && (cnt_q != 2'd0);

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = in_beat;
            else               ent1_d = in_beat;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = in_beat;
            end else begin
               ent0_d = ent1_q;
               ent1_d = in_beat;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 2'd0;
         rdy_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rdy_q <= (cnt_d != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
   end

   assign s_axis_video_tready = rdy_q;
   assign feed_vld            = (cnt_q != 2'd0);
   assign feed_beat           = ent0_q;
`else
   // rdy_q keeps tready low during reset and for the cycle rst is released
   logic rdy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= 1'b1;
   end

   assign s_axis_video_tready = en && rdy_q;
   assign feed_vld            = s_axis_video_tvalid && rdy_q;
   assign feed_beat           = {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
`endif

   assign pix_r = feed_beat[23:16];
   assign pix_b = feed_beat[15:8];
   assign pix_g = feed_beat[7:0];

   // valid/sideband for every stage plus the output word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0_q  <= 1'b0;
         last_p0_q <= 1'b0;
         user_p0_q <= 1'b0;
         vld_p1_q  <= 1'b0;
         last_p1_q <= 1'b0;
         user_p1_q <= 1'b0;
         vld_p2_q  <= 1'b0;
         last_p2_q <= 1'b0;
         user_p2_q <= 1'b0;
         data_p2_q <= 24'd0;
      end else if (en) begin
         // ---- S1 boundary ----
         vld_p0_q  <= feed_vld;
         last_p0_q <= feed_beat[24];
         user_p0_q <= feed_beat[25];
         // ---- S2 boundary ----
         vld_p1_q  <= vld_p0_q;
         last_p1_q <= last_p0_q;
         user_p1_q <= user_p0_q;
         // ---- S3 boundary ----
         vld_p2_q  <= vld_p1_q;
         last_p2_q <= last_p1_q;
         user_p2_q <= user_p1_q;
         data_p2_q <= {shift_sat(cr_p1_q, OFF_C, MIN_YC, MAX_C),
                       shift_sat(cb_p1_q, OFF_C, MIN_YC, MAX_C),
                       shift_sat(y_p1_q,  OFF_Y, MIN_YC, MAX_Y)};
      end
   end

   // arithmetic datapath, no reset
   always_ff @(posedge clk) begin
      if (en) begin
         // ---- S1 boundary ----
         prod_p0_q[0] <= coef_mul(pix_r, C_YR);
         prod_p0_q[1] <= coef_mul(pix_g, C_YG);
         prod_p0_q[2] <= coef_mul(pix_b, C_YB);
         prod_p0_q[3] <= coef_mul(pix_r, C_CBR);
         prod_p0_q[4] <= coef_mul(pix_g, C_CBG);
         prod_p0_q[5] <= coef_mul(pix_b, C_CBB);
         prod_p0_q[6] <= coef_mul(pix_r, C_CRR);
         prod_p0_q[7] <= coef_mul(pix_g, C_CRG);
         prod_p0_q[8] <= coef_mul(pix_b, C_CRB);
         // ---- S2 boundary ----
         y_p1_q  <= prod_p0_q[0] + prod_p0_q[1] + prod_p0_q[2] + RND;
         cb_p1_q <= prod_p0_q[3] + prod_p0_q[4] + prod_p0_q[5] + RND;
         cr_p1_q <= prod_p0_q[6] + prod_p0_q[7] + prod_p0_q[8] + RND;
      end
   end

   assign m_axis_video_tvalid = vld_p2_q;
   assign m_axis_video_tdata  = data_p2_q;
   assign m_axis_video_tlast  = last_p2_q;
   assign m_axis_video_tuser  = user_p2_q;

endmodule

// File: tb/tb_rgb2ycbcr_stream.sv
`timescale 1ns/1ps
module tb_rgb2ycbcr_stream;

`ifdef RGB2YCBCR_SKID_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] s_data;
   logic        s_valid, s_ready, s_last, s_user;
   logic [23:0] m_data;
   logic        m_valid, m_ready, m_last, m_user;

   always #5 clk = ~clk;

   rgb2ycbcr_stream dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_video_tdata  (s_data),
      .s_axis_video_tvalid (s_valid),
      .s_axis_video_tready (s_ready),
      .s_axis_video_tlast  (s_last),
      .s_axis_video_tuser  (s_user),
      .m_axis_video_tdata  (m_data),
      .m_axis_video_tvalid (m_valid),
      .m_axis_video_tready (m_ready),
      .m_axis_video_tlast  (m_last),
      .m_axis_video_tuser  (m_user)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [25:0] in_q[$];    // {tuser, tlast, rgb}
   logic [25:0] out_q[$];   // {tuser, tlast, ycbcr}
   int stable_err;
   bit timed_out;
   int last_cycles;

   logic [23:0] dir_pix [3];
   logic [23:0] dir_exp [3];

   // Reference conversion straight from the BT.601 integer formulas
   function automatic logic [23:0] ref_pix(input logic [23:0] rgb);
      int r, g, b, y, cb, cr;
      r  = int'(rgb[23:16]);
      b  = int'(rgb[15:8]);
      g  = int'(rgb[7:0]);
      y  = 16  + ((66 * r + 129 * g + 25 * b + 128) >>> 8);
      cb = 128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8);
      cr = 128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8);
      if (y < 16) y = 16;
      if (y > 235) y = 235;
      if (cb < 16) cb = 16;
      if (cb > 240) cb = 240;
      if (cr < 16) cr = 16;
      if (cr > 240) cr = 240;
      return {cr[7:0], cb[7:0], y[7:0]};
   endfunction

   function automatic logic [25:0] ref_beat(input logic [25:0] b);
      return {b[25:24], ref_pix(b[23:0])};
   endfunction

   // Stream driver/collector: presents in_q on the slave side, gathers output
   // beats into out_q, counts changes of a stalled output word.
   // mode 0: always ready, 1: scripted backpressure, 2: random ready
   task automatic drive_stream(input int mode, input int gap_pct);
      int idx, cyc, stall_left, limit;
      bit did_stall, prev_stall, in_acc;
      logic [25:0] prev_beat;
      idx = 0; cyc = 0; stall_left = 0; did_stall = 0; prev_stall = 0;
      prev_beat = '0;
      limit = in_q.size() * 20 + 100;
      out_q.delete();
      stable_err = 0;
      timed_out = 0;
      s_valid = 0;
      while (out_q.size() < in_q.size()) begin
         if (cyc >= limit) begin
            timed_out = 1;
            break;
         end
         case (mode)
            1: begin
               if (out_q.size() == 10 && !did_stall) begin
                  stall_left = 5;
                  did_stall = 1;
               end
               if (stall_left > 0) begin
                  m_ready = 0;
                  stall_left--;
               end else if (out_q.size() >= 30 && out_q.size() <= 40) begin
                  m_ready = cyc[0];
               end else begin
                  m_ready = 1;
               end
            end
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1;
         endcase
         if (!s_valid && idx < in_q.size() && $urandom_range(0, 99) >= gap_pct) begin
            {s_user, s_last, s_data} = in_q[idx];
            s_valid = 1;
         end
         @(negedge clk);
         if (prev_stall && {m_valid, m_user, m_last, m_data} !== {1'b1, prev_beat})
            stable_err++;
         prev_stall = m_valid && !m_ready;
         prev_beat = {m_user, m_last, m_data};
         if (m_valid && m_ready) out_q.push_back({m_user, m_last, m_data});
         in_acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (in_acc) begin
            idx++;
            s_valid = 0;
         end
         cyc++;
      end
      s_valid = 0;
      last_cycles = cyc;
   endtask

   task automatic test_reset();
      rst = 1; s_valid = 0; s_data = 0; s_last = 0; s_user = 0; m_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b expected 0", m_valid); end
      n_cmp++; if (m_data !== 24'h0) begin n_bad++; $display("FAIL rst_tdata: got %h expected 000000", m_data); end
      n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b expected 0", m_last); end
      n_cmp++; if (m_user !== 1'b0) begin n_bad++; $display("FAIL rst_tuser: got %b expected 0", m_user); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b expected 0", s_ready); end
      rst = 0;
      @(negedge clk);
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL tready_pre_edge: got %b expected 0", s_ready); end
      @(posedge clk); #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL tready_post_edge: got %b expected 1", s_ready); end
   endtask

   task automatic test_directed();
      int cyc;
      dir_pix[0] = 24'h000000; dir_exp[0] = 24'h808010;
      dir_pix[1] = 24'hFFFFFF; dir_exp[1] = 24'h8080EB;
      dir_pix[2] = 24'hFF0000; dir_exp[2] = 24'hF05A52;
      for (int i = 0; i < 3; i++) begin
         m_ready = 1; s_data = dir_pix[i]; s_last = 0; s_user = 0; s_valid = 1;
         @(negedge clk);
         n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL dir%0d_accept: got %b expected 1", i, s_ready); end
         @(posedge clk); #1;
         s_valid = 0;
         cyc = 1;
         while (m_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
         end
         n_cmp++; if (cyc != LAT) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, LAT); end
         n_cmp++; if (m_data !== dir_exp[i]) begin n_bad++; $display("FAIL dir%0d_data: got %h expected %h", i, m_data, dir_exp[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_stream(input string name);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL %s_timeout: got %0d beats expected %0d", name, out_q.size(), in_q.size()); end
      n_cmp++; if (stable_err != 0) begin n_bad++; $display("FAIL %s_stall_stable: got %0d changes expected 0", name, stable_err); end
      for (int i = 0; i < in_q.size(); i++) begin
         n_cmp++;
         if (i >= out_q.size()) begin
            n_bad++; $display("FAIL %s_beat%0d: got none expected %h", name, i, ref_beat(in_q[i]));
         end else if (out_q[i] !== ref_beat(in_q[i])) begin
            n_bad++; $display("FAIL %s_beat%0d: got %h expected %h", name, i, out_q[i], ref_beat(in_q[i]));
         end
      end
   endtask

   task automatic test_random();
      in_q.delete();
      for (int i = 0; i < 150; i++)
         in_q.push_back({$urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0, 24'($urandom)});
      drive_stream(2, 30);
      check_stream("random");
   endtask

   task automatic test_back_to_back();
      in_q.delete();
      for (int i = 0; i < 32; i++) in_q.push_back({2'b00, 24'($urandom)});
      drive_stream(0, 0);
      check_stream("b2b");
      n_cmp++; if (last_cycles != 32 + LAT) begin n_bad++; $display("FAIL b2b_throughput: got %0d cycles expected %0d", last_cycles, 32 + LAT); end
   endtask

   task automatic test_backpressure();
      logic [7:0] v;
      in_q.delete();
      for (int i = 0; i < 64; i++) begin
         v = 8'(i * 4);
         in_q.push_back({2'b00, v, 8'(255 - i * 4), 8'(i * 3)});
      end
      drive_stream(1, 0);
      check_stream("bp");
   endtask

   task automatic test_sideband();
      in_q.delete();
      for (int i = 0; i < 8; i++) in_q.push_back({i == 0, i == 7, 24'($urandom)});
      drive_stream(0, 0);
      check_stream("sideband");
      for (int i = 0; i < 8 && i < out_q.size(); i++) begin
         n_cmp++; if (out_q[i][25:24] !== {i == 0, i == 7}) begin n_bad++; $display("FAIL sb_flags%0d: got %b expected %b", i, out_q[i][25:24], {i == 0, i == 7}); end
      end
   endtask

   task automatic test_reset_midstream();
      int acc, cyc, seen;
      m_ready = 0; acc = 0; cyc = 0;
      while (acc < 3 && cyc < 20) begin
         s_data = 24'($urandom); s_last = 0; s_user = 0; s_valid = 1;
         @(negedge clk);
         if (s_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 0;
      n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL mid_accepted: got %0d expected 3", acc); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight: got %b expected 1", m_valid); end
      #2 rst = 1;
      #1;
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_tvalid: got %b expected 0", m_valid); end
      n_cmp++; if (m_data !== 24'h0) begin n_bad++; $display("FAIL mid_async_tdata: got %h expected 000000", m_data); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL mid_async_tready: got %b expected 0", s_ready); end
      repeat (2) @(posedge clk);
      #1;
      rst = 0; m_ready = 1; seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (m_valid) seen++;
         @(posedge clk); #1;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_stale: got %0d beats expected 0", seen); end
      in_q.delete();
      in_q.push_back({2'b00, 24'($urandom)});
      drive_stream(0, 0);
      check_stream("mid_next");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_sideband();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
